// File: rtl/adau_ctrl_arbiter.sv
// Arbiter between the ADAU init command list and a one-entry CPU command buffer,
// feeding a single SPI master and enforcing a CLATCH recovery gap after each command.
module adau_ctrl_arbiter #(
   parameter int unsigned GAP_CYCLES = 4,
   parameter int unsigned CMD_W      = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [CMD_W-1:0] init_cmd,
   input  logic             init_valid,
   output logic             init_ready,
   input  logic             init_done,
   input  logic [CMD_W-1:0] cpu_cmd,
   input  logic             cpu_wr,
   output logic             cpu_full,
   output logic [CMD_W-1:0] spi_data,
   output logic             spi_valid,
   input  logic             spi_ready,
   output logic             busy,
   output logic [15:0]      cmd_count,
   output logic             cpu_drop
);

   localparam int unsigned CNT_W = 16;
   localparam int unsigned GAP_W = 8;
   localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CYCLES == 0) ? GAP_W'(0) : GAP_W'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_GAP   = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [GAP_W-1:0]   r_gap_cnt;
   logic [CMD_W-1:0]   r_spi_data;
   logic               r_spi_valid;
   logic [CMD_W-1:0]   r_cpu_buf;
   logic               r_cpu_full;
   logic               r_cpu_drop;
   logic [CNT_W-1:0]   r_cmd_count;
   logic               r_grant_cpu;
   logic               r_last_cpu;

   logic w_init_req;
   logic w_cpu_req;
   logic w_pick_cpu;
   logic w_pick_init;
   logic w_grant;
   logic w_xfer;
   logic w_gap_done;

   // CPU is locked out until the init list is done; on a tie the source not granted last wins
   assign w_init_req  = init_valid;
   assign w_cpu_req   = r_cpu_full & init_done;
   assign w_pick_cpu  = w_cpu_req & (~w_init_req | ~r_last_cpu);
   assign w_pick_init = w_init_req & ~w_pick_cpu;
   assign w_grant     = (r_state == S_IDLE) & (w_pick_cpu | w_pick_init);
   assign w_xfer      = (r_state == S_ISSUE) & spi_ready;
   assign w_gap_done  = (r_gap_cnt == GAP_LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_pick_cpu | w_pick_init) w_state_nxt = S_ISSUE;
         S_ISSUE: if (w_xfer) w_state_nxt = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
         S_GAP:   if (w_gap_done) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_spi_valid <= 1'b0;
         r_spi_data  <= '0;
         r_grant_cpu <= 1'b0;
         r_last_cpu  <= 1'b1;
         r_cmd_count <= '0;
         r_gap_cnt   <= '0;
      end else begin
         r_spi_valid <= (w_state_nxt == S_ISSUE);
         if (w_grant) begin
            r_spi_data  <= w_pick_cpu ? r_cpu_buf : init_cmd;
            r_grant_cpu <= w_pick_cpu;
            r_last_cpu  <= w_pick_cpu;
         end
         if (w_xfer) r_cmd_count <= r_cmd_count + CNT_W'(1);
         if (w_xfer)                r_gap_cnt <= '0;
         else if (r_state == S_GAP) r_gap_cnt <= r_gap_cnt + GAP_W'(1);
      end
   end

   // Single-entry CPU buffer: a write while occupied (including the clearing cycle) is discarded
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cpu_buf  <= '0;
         r_cpu_full <= 1'b0;
         r_cpu_drop <= 1'b0;
      end else begin
         r_cpu_drop <= cpu_wr & r_cpu_full;
         if (w_xfer && r_grant_cpu) begin
            r_cpu_full <= 1'b0;
         end else if (cpu_wr && !r_cpu_full) begin
            r_cpu_full <= 1'b1;
            r_cpu_buf  <= cpu_cmd;
         end
      end
   end

   assign spi_valid  = r_spi_valid;
   assign spi_data   = r_spi_data;
   assign cpu_full   = r_cpu_full;
   assign cpu_drop   = r_cpu_drop;
   assign cmd_count  = r_cmd_count;
   assign init_ready = w_xfer & ~r_grant_cpu;
   assign busy       = (r_state != S_IDLE) | r_cpu_full | init_valid;

endmodule

// File: tb/tb_adau_ctrl_arbiter.sv
// Directed bench for adau_ctrl_arbiter: GAP_CYCLES=4 instance for arbitration/timing,
// GAP_CYCLES=0 instance on a fast clock for the command counter wrap.
module tb_adau_ctrl_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] init_cmd;
   logic        init_valid;
   logic        init_ready;
   logic        init_done;
   logic [31:0] cpu_cmd;
   logic        cpu_wr;
   logic        cpu_full;
   logic [31:0] spi_data;
   logic        spi_valid;
   logic        spi_ready;
   logic        busy;
   logic [15:0] cmd_count;
   logic        cpu_drop;

   logic        clk2 = 1'b0;
   logic        rst2_n;
   logic        init_valid2;
   logic        init_ready2;
   logic        init_done2;
   logic        cpu_full2;
   logic [31:0] spi_data2;
   logic        spi_valid2;
   logic        spi_ready2;
   logic        busy2;
   logic [15:0] cmd_count2;
   logic        cpu_drop2;

   int errors = 0;
   int checks = 0;

   always #5 clk  = ~clk;
   always #1 clk2 = ~clk2;

   adau_ctrl_arbiter #(.GAP_CYCLES(4), .CMD_W(32)) dut (
      .clk(clk), .reset_n(reset_n),
      .init_cmd(init_cmd), .init_valid(init_valid), .init_ready(init_ready), .init_done(init_done),
      .cpu_cmd(cpu_cmd), .cpu_wr(cpu_wr), .cpu_full(cpu_full),
      .spi_data(spi_data), .spi_valid(spi_valid), .spi_ready(spi_ready),
      .busy(busy), .cmd_count(cmd_count), .cpu_drop(cpu_drop)
   );

   adau_ctrl_arbiter #(.GAP_CYCLES(0), .CMD_W(32)) dut_wrap (
      .clk(clk2), .reset_n(rst2_n),
      .init_cmd(32'h0000_0042), .init_valid(init_valid2), .init_ready(init_ready2), .init_done(init_done2),
      .cpu_cmd(32'h0), .cpu_wr(1'b0), .cpu_full(cpu_full2),
      .spi_data(spi_data2), .spi_valid(spi_valid2), .spi_ready(spi_ready2),
      .busy(busy2), .cmd_count(cmd_count2), .cpu_drop(cpu_drop2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   int          n_edge;
   int          edge_t [8];
   logic [31:0] edge_d [8];
   logic        prev_v;
   int          drops;
   logic        stable;
   int          rdy_seen;
   int          n_xfer;
   logic        timed_out;
   logic        seen2;

   initial begin
      reset_n = 1'b0; rst2_n = 1'b0;
      init_cmd = '0; init_valid = 1'b0; init_done = 1'b0;
      cpu_cmd = '0; cpu_wr = 1'b0; spi_ready = 1'b0;
      init_valid2 = 1'b0; init_done2 = 1'b0; spi_ready2 = 1'b0;
      #1;
      chk("rst_spi_valid", 32'(spi_valid), 32'd0);
      chk("rst_spi_data", spi_data, 32'd0);
      chk("rst_cpu_full", 32'(cpu_full), 32'd0);
      chk("rst_cmd_count", 32'(cmd_count), 32'd0);
      chk("rst_cpu_drop", 32'(cpu_drop), 32'd0);
      chk("rst_init_ready", 32'(init_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      step(); step();
      reset_n = 1'b1; rst2_n = 1'b1;
      step();

      // init has priority before init_done; CPU command held until then
      init_done = 1'b0; spi_ready = 1'b1;
      init_valid = 1'b1; init_cmd = 32'h4000_0001;
      cpu_wr = 1'b1; cpu_cmd = 32'h4000_4009;
      step();
      cpu_wr = 1'b0; #1;
      chk("r036_valid", 32'(spi_valid), 32'd1);
      chk("r036_data_init", spi_data, 32'h4000_0001);
      chk("r036_cpu_full", 32'(cpu_full), 32'd1);
      chk("r036_init_ready", 32'(init_ready), 32'd1);
      step();
      init_valid = 1'b0; #1;
      chk("r036_ready_pulse", 32'(init_ready), 32'd0);
      chk("r036_count1", 32'(cmd_count), 32'd1);
      chk("r036_gap_valid", 32'(spi_valid), 32'd0);
      repeat (6) step();
      chk("r036_cpu_held", 32'(spi_valid), 32'd0);
      chk("r036_cpu_full_held", 32'(cpu_full), 32'd1);
      chk("r036_busy", 32'(busy), 32'd1);
      init_done = 1'b1;
      step();
      #1;
      chk("r036_cpu_valid", 32'(spi_valid), 32'd1);
      chk("r036_cpu_data", spi_data, 32'h4000_4009);
      chk("r036_no_init_ready", 32'(init_ready), 32'd0);
      step();
      chk("r036_cpu_cleared", 32'(cpu_full), 32'd0);
      chk("r036_count2", 32'(cmd_count), 32'd2);
      repeat (4) step();

      // round robin with both sources continuously requesting
      init_valid = 1'b1; init_cmd = 32'h1111_0000; cpu_cmd = 32'h2222_0000;
      n_edge = 0; prev_v = 1'b0; drops = 0;
      for (int i = 0; i < 24; i++) begin
         cpu_wr = !cpu_full;
         if (spi_valid && !prev_v && n_edge < 8) begin
            edge_t[n_edge] = i;
            edge_d[n_edge] = spi_data;
            n_edge++;
         end
         prev_v = spi_valid;
         if (cpu_drop) drops++;
         step();
      end
      init_valid = 1'b0; cpu_wr = 1'b0;
      chk("r037_n_grants", 32'(n_edge), 32'd4);
      chk("r037_t0", 32'(edge_t[0]), 32'd1);
      chk("r037_t1", 32'(edge_t[1]), 32'd7);
      chk("r037_t2", 32'(edge_t[2]), 32'd13);
      chk("r037_t3", 32'(edge_t[3]), 32'd19);
      chk("r037_g0_init", edge_d[0], 32'h1111_0000);
      chk("r037_g1_cpu", edge_d[1], 32'h2222_0000);
      chk("r037_g2_init", edge_d[2], 32'h1111_0000);
      chk("r037_g3_cpu", edge_d[3], 32'h2222_0000);
      chk("r037_no_drops", 32'(drops), 32'd0);
      step();
      chk("r024_single_cpu_valid", 32'(spi_valid), 32'd1);
      chk("r024_single_cpu_data", spi_data, 32'h2222_0000);
      repeat (5) step();
      chk("r037_count", 32'(cmd_count), 32'd7);
      chk("r037_idle_busy", 32'(busy), 32'd0);

      // backpressure: command held stable, later init_cmd changes ignored
      spi_ready = 1'b0; init_valid = 1'b1; init_cmd = 32'hA5A5_0003;
      step();
      init_cmd = 32'hDEAD_BEEF;
      stable = 1'b1; rdy_seen = 0;
      for (int i = 0; i < 10; i++) begin
         #1;
         if (!(spi_valid === 1'b1 && spi_data === 32'hA5A5_0003)) stable = 1'b0;
         if (init_ready !== 1'b0) rdy_seen++;
         step();
      end
      chk("r038_stable", 32'(stable), 32'd1);
      chk("r038_no_early_ready", 32'(rdy_seen), 32'd0);
      spi_ready = 1'b1; #1;
      chk("r038_ready_on_xfer", 32'(init_ready), 32'd1);
      chk("r038_valid_on_xfer", 32'(spi_valid), 32'd1);
      step();
      init_valid = 1'b0; #1;
      chk("r038_ready_single", 32'(init_ready), 32'd0);
      chk("r038_valid_low", 32'(spi_valid), 32'd0);
      chk("r038_count", 32'(cmd_count), 32'd8);
      repeat (4) step();

      // CPU overflow drops: while full, and in the clearing cycle
      init_valid = 1'b1; init_cmd = 32'h1234_0005; spi_ready = 1'b0;
      cpu_wr = 1'b1; cpu_cmd = 32'h0000_00C1;
      step();
      chk("r039_full", 32'(cpu_full), 32'd1);
      chk("r039_no_drop_yet", 32'(cpu_drop), 32'd0);
      cpu_cmd = 32'h0000_BAD1;
      step();
      cpu_wr = 1'b0;
      chk("r039_drop_pulse", 32'(cpu_drop), 32'd1);
      step();
      chk("r039_drop_once", 32'(cpu_drop), 32'd0);
      spi_ready = 1'b1;
      step();
      init_valid = 1'b0;
      chk("r039_count9", 32'(cmd_count), 32'd9);
      repeat (5) step();
      chk("r039_cpu_valid", 32'(spi_valid), 32'd1);
      chk("r039_buf_unchanged", spi_data, 32'h0000_00C1);
      cpu_wr = 1'b1; cpu_cmd = 32'h0000_BAD2;
      step();
      cpu_wr = 1'b0;
      chk("r039_clear_drop", 32'(cpu_drop), 32'd1);
      chk("r039_clear_full", 32'(cpu_full), 32'd0);
      chk("r039_count10", 32'(cmd_count), 32'd10);
      step();
      chk("r039_drop_end", 32'(cpu_drop), 32'd0);
      chk("r039_stays_empty", 32'(cpu_full), 32'd0);
      repeat (3) step();

      // asynchronous reset in the middle of ISSUE
      cpu_wr = 1'b1; cpu_cmd = 32'h0000_0077; spi_ready = 1'b0;
      step();
      cpu_wr = 1'b0;
      step();
      chk("r040_in_issue", 32'(spi_valid), 32'd1);
      chk("r040_count_pre", 32'(cmd_count), 32'd10);
      #2;
      reset_n = 1'b0; init_done = 1'b0;
      #1;
      chk("r040_async_valid", 32'(spi_valid), 32'd0);
      chk("r040_async_count", 32'(cmd_count), 32'd0);
      chk("r040_async_full", 32'(cpu_full), 32'd0);
      chk("r040_async_data", spi_data, 32'd0);
      spi_ready = 1'b1;
      step();
      reset_n = 1'b1; #1;
      chk("r035_hold_valid", 32'(spi_valid), 32'd0);
      step();
      chk("r040_no_xfer", 32'(cmd_count), 32'd0);
      chk("r040_no_reissue", 32'(spi_valid), 32'd0);
      init_done = 1'b1; cpu_wr = 1'b1; cpu_cmd = 32'h0000_0088;
      step();
      cpu_wr = 1'b0; init_valid = 1'b1; init_cmd = 32'h0000_0099;
      step();
      chk("r033_tie_init_first", spi_data, 32'h0000_0099);
      step();
      init_valid = 1'b0;
      chk("r033_count_after", 32'(cmd_count), 32'd1);

      // counter wrap on the zero-gap instance
      init_done2 = 1'b1; spi_ready2 = 1'b1; init_valid2 = 1'b1;
      n_xfer = 0; timed_out = 1'b1; seen2 = 1'b0;
      for (int k = 0; k < 140000; k++) begin
         @(negedge clk2);
         if (spi_valid2 === 1'b1) n_xfer++;
         if (n_xfer == 2 && !seen2) begin
            seen2 = 1'b1;
            chk("r029_gap0_spacing", 32'(cmd_count2), 32'd1);
         end
         if (n_xfer == 65536) begin
            timed_out = 1'b0;
            break;
         end
      end
      chk("r041_timeout", 32'(timed_out), 32'd0);
      init_valid2 = 1'b0;
      @(posedge clk2);
      @(negedge clk2);
      chk("r041_wrap", 32'(cmd_count2), 32'd0);
      chk("r041_idle", 32'(spi_valid2), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/adau_ctrl_arbiter.md
ADAU_CTRL_ARBITER -- requirements
Module: adau_ctrl_arbiter

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 4, idle cycles enforced after each accepted command (CLATCH recovery), range 0..255.
REQ-002 SHALL have parameter CMD_W, default 32, command word width.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 init_cmd  in  CMD_W  command from init command list.
REQ-006 init_valid  in  1  init command present.
REQ-007 init_ready  out  1  init command accepted this cycle when high with init_valid.
REQ-008 init_done  in  1  init list finished; level, stays high until reset.
REQ-009 cpu_cmd  in  CMD_W  CPU-written command from bus logic.
REQ-010 cpu_wr  in  1  one-cycle write strobe into CPU buffer.
REQ-011 cpu_full  out  1  CPU buffer occupied.
REQ-012 spi_data  out  CMD_W  command to SPI master.
REQ-013 spi_valid  out  1  command offered to SPI master.
REQ-014 spi_ready  in  1  SPI master idle and able to accept.
REQ-015 busy  out  1  arbiter not in IDLE or any request pending.
REQ-016 cmd_count  out  16  number of commands handed to SPI master, wraps modulo 2^16.
REQ-017 cpu_drop  out  1  one-cycle pulse: cpu_wr while cpu_full, write discarded.

Function
REQ-018 SHALL implement FSM states IDLE, ISSUE, GAP.
REQ-019 IDLE: select a source per REQ-022..024; if one selected, latch its command into spi_data, record grant, go ISSUE next cycle.
REQ-020 ISSUE: spi_valid=1, spi_data stable; on spi_valid&&spi_ready transfer completes: increment cmd_count, release source (REQ-025), go GAP, or IDLE if GAP_CYCLES=0.
REQ-021 GAP: spi_valid=0; count GAP_CYCLES cycles, then IDLE; new requests only registered, not issued.
REQ-022 While init_done=0, only the init source SHALL be granted; CPU commands are buffered and held.
REQ-023 After init_done=1 with both sources requesting, SHALL grant round-robin: the source not granted last wins; last-grant resets to CPU (init wins first tie).
REQ-024 Single requester SHALL be granted regardless of round-robin pointer.
REQ-025 init_ready SHALL be a one-cycle pulse coincident with the SPI transfer of an init-granted command; never asserted otherwise.
REQ-026 CPU buffer: one entry; cpu_wr with cpu_full=0 stores cpu_cmd, cpu_full=1 next cycle; cleared the cycle after transfer of a CPU-granted command.
REQ-027 cpu_wr in the same cycle the buffer clears SHALL be dropped (cpu_drop=1), buffer clears; no bypass.
REQ-028 init_cmd SHALL be sampled only in IDLE at grant; later changes ignored until next grant.
REQ-029 Latency: request present in IDLE -> spi_valid high 1 cycle later; min command-to-command spacing = 2+GAP_CYCLES cycles with spi_ready held high.
REQ-030 spi_valid SHALL never deassert in ISSUE before transfer (AXI-style hold).
REQ-031 busy = (state != IDLE) | cpu_full | init_valid.
REQ-032 cmd_count wraps 0xFFFF -> 0x0000 without flag.

Reset
REQ-033 On reset_n=0, immediately: state IDLE, spi_valid=0, spi_data=0, init_ready=0, cpu_full=0, cpu_drop=0, cmd_count=0, GAP counter=0, last-grant=CPU.
REQ-034 Reset mid-ISSUE SHALL abort the command without a transfer; buffered CPU command is lost.
REQ-035 Outputs SHALL leave reset values only on the first clk edge after reset_n deasserts.

Verification
REQ-036 init_done=0, init_valid with cmd 0x4000_0001, cpu_wr 0x4000_4009 same cycle, spi_ready=1 -> init transferred first, CPU command held until init_done=1, then issued; cmd_count=2.
REQ-037 init_done=1, both sources continuously requesting, GAP_CYCLES=4 -> grants alternate init,cpu,init,cpu; spi_valid rising edges 6 cycles apart.
REQ-038 spi_ready=0 for 10 cycles during ISSUE -> spi_valid and spi_data stable all 10 cycles; single transfer when spi_ready rises; init_ready single-cycle pulse.
REQ-039 cpu_wr while cpu_full=1 -> cpu_drop pulses once, buffer contents unchanged; cpu_wr in clearing cycle -> also dropped, cpu_full=0 next cycle.
REQ-040 reset_n low for 1 cycle during ISSUE -> spi_valid=0 asynchronously, cmd_count=0, cpu_full=0, no transfer counted.
REQ-041 65536 transfers -> cmd_count returns to 0x0000.
